// File: rtl/bcd_counter_4dig_pkg.sv
// rtl/bcd_counter_4dig_pkg.sv - shared state encoding and BCD constants for the 4-digit counter
package bcd_counter_4dig_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter_4dig_if.sv
// rtl/bcd_counter_4dig_if.sv - control and display-digit bundle of the 4-digit BCD counter
interface bcd_counter_4dig_if;

    logic        i_start;
    logic        i_clear;
    logic        i_up;
    logic [15:0] o_digits;
    logic        o_running;
    logic        o_step;
    logic        o_wrap;

    modport master (
        output i_start,
        output i_clear,
        output i_up,
        input  o_digits,
        input  o_running,
        input  o_step,
        input  o_wrap
    );

    modport slave (
        input  i_start,
        input  i_clear,
        input  i_up,
        output o_digits,
        output o_running,
        output o_step,
        output o_wrap
    );

endinterface

// File: rtl/bcd_counter_4dig_bcd_digit.sv
// rtl/bcd_counter_4dig_bcd_digit.sv - one BCD digit stage with carry/borrow, chained units to thousands
module bcd_digit
    import bcd_counter_4dig_pkg::*;
(
    input  logic       step_in,
    input  logic       up,
    input  logic [3:0] digit,
    output logic [3:0] digit_nxt,
    output logic       carry_out
);

    // Advance this digit only when the lower stage rolls over; wrap 9<->0 and ripple onward
    always_comb begin
        digit_nxt = digit;
        carry_out = 1'b0;
        if (step_in) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    digit_nxt = 4'd0;
                    carry_out = 1'b1;
                end else begin
                    digit_nxt = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    digit_nxt = BCD_MAX;
                    carry_out = 1'b1;
                end else begin
                    digit_nxt = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4dig.sv
// rtl/bcd_counter_4dig.sv - four-digit BCD up/down counter with prescaler and run/pause/clear FSM
module bcd_counter_4dig
    import bcd_counter_4dig_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int PRE_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    bcd_counter_4dig_if.slave   bus
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [15:0]      digits_q;
    logic [15:0]      digits_nxt;
    logic             step_q;
    logic             wrap_q;
    logic             tc;
    logic             step_go;
    logic [4:0]       carry;

    // A step is due at prescaler terminal count; clear or a pausing start pulse cancels it
    assign tc      = (state_q == ST_RUNNING) && (pre_q == PRE_LAST);
    assign step_go = tc && !bus.i_clear && !bus.i_start;
    assign carry[0] = step_go;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit u_digit (
            .step_in   (carry[g]),
            .up        (bus.i_up),
            .digit     (digits_q[4*g +: 4]),
            .digit_nxt (digits_nxt[4*g +: 4]),
            .carry_out (carry[g+1])
        );
    end

    // Next state: clear dominates, start toggles run/pause; prescaler only advances while running undisturbed
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        if (bus.i_clear) begin
            state_d = ST_STOPPED;
            pre_d   = '0;
        end else begin
            if (bus.i_start) begin
                case (state_q)
                    ST_STOPPED: state_d = ST_RUNNING;
                    ST_RUNNING: state_d = ST_PAUSED;
                    ST_PAUSED:  state_d = ST_RUNNING;
                    default:    state_d = ST_STOPPED;
                endcase
            end
            if (state_q == ST_STOPPED) begin
                pre_d = '0;
            end else if ((state_q == ST_RUNNING) && !bus.i_start) begin
                pre_d = tc ? '0 : pre_q + 1'b1;
            end
        end
    end

    // State, prescaler and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STOPPED;
            pre_q    <= '0;
            digits_q <= 16'h0000;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            step_q  <= step_go;
            wrap_q  <= step_go && carry[4];
            if (bus.i_clear) begin
                digits_q <= 16'h0000;
            end else if (step_go) begin
                digits_q <= digits_nxt;
            end
        end
    end

    assign bus.o_digits  = digits_q;
    assign bus.o_running = (state_q == ST_RUNNING);
    assign bus.o_step    = step_q;
    assign bus.o_wrap    = wrap_q;

endmodule
